// File: rtl/axi_slave_wr_arbiter.sv
// axi_slave_wr_arbiter: round-robin AW/W arbiter for one slave port with an in-order B-response owner FIFO
module axi_slave_wr_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IDX_W           = $clog2(NUM_MASTERS)
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic [NUM_MASTERS-1:0]             M_AWVALID,
  output logic [NUM_MASTERS-1:0]             M_AWREADY,
  output logic                               S_AWVALID,
  input  logic                               S_AWREADY,
  input  logic [NUM_MASTERS-1:0]             M_WVALID,
  input  logic [NUM_MASTERS-1:0]             M_WLAST,
  output logic [NUM_MASTERS-1:0]             M_WREADY,
  output logic                               S_WVALID,
  output logic                               S_WLAST,
  input  logic                               S_WREADY,
  input  logic                               S_BVALID,
  input  logic                               S_BREADY,
  output logic [IDX_W-1:0]                   aw_sel,
  output logic [IDX_W-1:0]                   w_sel,
  output logic [IDX_W-1:0]                   b_sel,
  output logic                               b_sel_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_orphan_b
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AW   = 2'd1;
  localparam logic [1:0] W    = 2'd2;
  logic [1:0] state;
  logic [IDX_W-1:0] rr_ptr, grant_idx, idx;
  logic grant_found, aw_hs, w_last_hs, push, pop, empty, full;
  logic [IDX_W-1:0] fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  assign S_AWVALID   = state == AW && M_AWVALID[aw_sel];
  assign M_AWREADY   = (state == AW && S_AWREADY) ? ONE << aw_sel : '0;
  assign S_WVALID    = state == W && M_WVALID[w_sel];
  assign S_WLAST     = state == W && M_WLAST[w_sel];
  assign M_WREADY    = (state == W && S_WREADY) ? ONE << w_sel : '0;
  assign aw_hs       = S_AWVALID && S_AWREADY;
  assign w_last_hs   = S_WVALID && S_WREADY && S_WLAST;
  assign empty       = outstanding == '0;
  assign full        = outstanding == MAX_CNT;
  assign push        = aw_hs;
  assign pop         = S_BVALID && S_BREADY && !empty;
  assign b_sel_valid = !empty;
  assign b_sel       = empty ? '0 : fifo[rd_ptr];
  // scan downward so the requester closest to rr_ptr is the one left standing
  always_comb begin
    grant_found = 1'b0;
    grant_idx = '0;
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (M_AWVALID[idx]) begin
        grant_found = 1'b1;
        grant_idx = idx;
      end
    end
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
      rr_ptr <= '0;
      aw_sel <= '0;
      w_sel <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      outstanding <= '0;
      err_orphan_b <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_found && !full) begin
          aw_sel <= grant_idx;
          w_sel <= grant_idx;
          state <= AW;
        end
        AW: if (aw_hs) begin
          rr_ptr <= (aw_sel == LAST) ? '0 : aw_sel + 1'b1;
          state <= W;
        end
        W: if (w_last_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) outstanding <= push ? outstanding + 1'b1 : outstanding - 1'b1;
      if (S_BVALID && empty) err_orphan_b <= 1'b1;
    end
  end
  always_ff @(posedge ACLK) begin
    if (push) fifo[wr_ptr] <= aw_sel;
  end
endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// tb_axi_slave_wr_arbiter: scoreboard bench; expected grants queued by stimulus, checked at handshakes
module tb_axi_slave_wr_arbiter;
  localparam int NM = 4;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [3:0] M_AWVALID = '0, M_WVALID = '0, M_WLAST = '0;
  logic [3:0] M_AWREADY, M_WREADY;
  logic S_AWREADY = 1'b0, S_WREADY = 1'b0, S_BVALID = 1'b0, S_BREADY = 1'b0;
  logic S_AWVALID, S_WVALID, S_WLAST;
  logic [1:0] aw_sel, w_sel, b_sel;
  logic b_sel_valid, err_orphan_b;
  logic [2:0] outstanding;
  int n_cmp = 0, n_err = 0;
  int pend[4] = '{default: 0};
  int len[4] = '{default: 1};
  int st[4] = '{default: 0};
  int beat[4] = '{default: 0};
  int bpend = 0;
  logic aw_rdy = 1'b1, w_rdy = 1'b1, w_tog = 1'b0, b_rdy = 1'b0, force_b = 1'b0;
  int exp_aw[$];
  int exp_b[$];
  int cur_w = 0;
  always #5 ACLK = ~ACLK;
  axi_slave_wr_arbiter #(.NUM_MASTERS(4), .MAX_OUTSTANDING(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .M_WVALID(M_WVALID), .M_WLAST(M_WLAST), .M_WREADY(M_WREADY),
    .S_WVALID(S_WVALID), .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .aw_sel(aw_sel), .w_sel(w_sel), .b_sel(b_sel), .b_sel_valid(b_sel_valid),
    .outstanding(outstanding), .err_orphan_b(err_orphan_b)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge ACLK);
    #2;
  endtask
  task automatic chk_reset(input string nm);
    chk(nm, {M_AWREADY, M_WREADY, S_AWVALID, S_WVALID, S_WLAST, b_sel_valid, b_sel,
             err_orphan_b, outstanding, aw_sel, w_sel}, '0);
  endtask
  task automatic drain(input string nm);
    int k = 0;
    while (!(exp_aw.size() == 0 && exp_b.size() == 0 && outstanding == 0 && !S_WVALID) && k < 300) begin
      step();
      k++;
    end
    chk(nm, k < 300, 1'b1);
  endtask
  // master and slave-side models: sample handshakes at the edge, drive 1 time unit later
  initial begin
    forever begin : drv
      logic [3:0] awh, wh;
      logic bh, rs;
      @(posedge ACLK);
      awh = M_AWVALID & M_AWREADY;
      wh = M_WVALID & M_WREADY;
      bh = S_BVALID & S_BREADY;
      rs = !ARESETn;
      #1;
      if (rs) begin
        for (int m = 0; m < NM; m++) begin
          st[m] = 0;
          beat[m] = 0;
          pend[m] = 0;
        end
        bpend = 0;
      end else begin
        if (bh && bpend > 0) bpend--;
        for (int m = 0; m < NM; m++) begin
          case (st[m])
            0: if (pend[m] > 0) begin st[m] = 1; pend[m]--; end
            1: if (awh[m]) begin st[m] = 2; beat[m] = 0; end
            2: if (wh[m]) begin
              if (beat[m] == len[m] - 1) begin st[m] = 0; bpend++; end
              else beat[m]++;
            end
            default: st[m] = 0;
          endcase
        end
      end
      for (int m = 0; m < NM; m++) begin
        M_AWVALID[m] = st[m] == 1;
        M_WVALID[m] = st[m] == 2;
        M_WLAST[m] = st[m] == 2 && beat[m] == len[m] - 1;
      end
      S_AWREADY = aw_rdy;
      S_WREADY = w_tog ? !S_WREADY : w_rdy;
      S_BVALID = force_b || bpend > 0;
      S_BREADY = b_rdy;
    end
  end
  always @(negedge ACLK) begin : mon
    int e;
    logic [3:0] oh;
    if (!ARESETn) exp_b.delete();
    else begin
      if (S_AWVALID && S_AWREADY) begin
        if (exp_aw.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL aw_unexpected: handshake for aw_sel=%0d with no grant expected", aw_sel);
        end else begin
          e = exp_aw.pop_front();
          oh = 4'b0001 << e;
          chk("aw_sel", aw_sel, e);
          chk("aw_ready_onehot", M_AWREADY, oh);
          exp_b.push_back(e);
          cur_w = e;
        end
      end
      if (S_WVALID && S_WREADY) begin
        oh = 4'b0001 << cur_w;
        chk("w_sel", w_sel, cur_w);
        chk("w_ready_onehot", M_WREADY, oh);
      end
      if (S_BVALID && S_BREADY && b_sel_valid) begin
        if (exp_b.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b_unexpected: B popped for b_sel=%0d with none expected", b_sel);
        end else chk("b_sel", b_sel, exp_b.pop_front());
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int beats, k;
    repeat (3) step();
    chk_reset("reset_state");
    ARESETn = 1'b1;
    step();
    // single write from master 2
    exp_aw.push_back(2);
    pend[2] = 1;
    step();
    step();
    chk("t1_grant", {S_AWVALID, M_AWREADY, aw_sel}, {1'b1, 4'b0100, 2'd2});
    step();
    chk("t1_wlast_phase", {S_WVALID, S_WLAST, M_WREADY}, {2'b11, 4'b0100});
    step();
    chk("t1_b_fifo", {b_sel_valid, b_sel, outstanding}, {1'b1, 2'd2, 3'd1});
    b_rdy = 1'b1;
    drain("t1_drain");
    chk("t1_after_b", {b_sel_valid, outstanding}, '0);
    // round-robin among four persistent requesters
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    step();
    for (int m = 0; m < NM; m++) len[m] = 2;
    exp_aw = '{0, 1, 2, 3, 0};
    pend[0] = 2;
    pend[1] = 1;
    pend[2] = 1;
    pend[3] = 1;
    drain("t2_drain");
    // AW and W backpressure
    aw_rdy = 1'b0;
    len[1] = 4;
    exp_aw.push_back(1);
    pend[1] = 1;
    step();
    step();
    repeat (5) begin
      chk("t3_aw_hold", {S_AWVALID, M_AWREADY, aw_sel}, {1'b1, 4'b0000, 2'd1});
      step();
    end
    aw_rdy = 1'b1;
    w_tog = 1'b1;
    beats = 0;
    for (k = 0; k < 40; k++) begin
      if (beats == 4 && !S_WVALID) break;
      chk("t3_aw_sel_stable", aw_sel, 2'd1);
      if (S_WVALID) chk("t3_wready_follow", M_WREADY, S_WREADY ? 4'b0010 : 4'b0000);
      if (S_WVALID && S_WREADY) beats++;
      step();
    end
    chk("t3_beats", beats, 4);
    chk("t3_idle_after_wlast", {S_WVALID, S_AWVALID, M_WREADY}, '0);
    w_tog = 1'b0;
    w_rdy = 1'b1;
    drain("t3_drain");
    // FIFO full blocks the fifth grant
    b_rdy = 1'b0;
    len[2] = 1;
    repeat (5) exp_aw.push_back(2);
    pend[2] = 5;
    k = 0;
    while (outstanding != 4 && k < 100) begin
      step();
      k++;
    end
    chk("t4_fill", outstanding, 4);
    step();
    step();
    step();
    chk("t4_req_present", M_AWVALID, 4'b0100);
    chk("t4_full_block", {S_AWVALID, M_AWREADY, outstanding}, {1'b0, 4'b0000, 3'd4});
    b_rdy = 1'b1;
    step();
    b_rdy = 1'b0;
    step();
    chk("t4_pop_no_grant_yet", {S_AWVALID, outstanding}, {1'b0, 3'd3});
    b_rdy = 1'b1;
    step();
    b_rdy = 1'b0;
    chk("t4_fifth_grant", {S_AWVALID, aw_sel}, {1'b1, 2'd2});
    step();
    chk("t4_push_pop_same", outstanding, 3);
    b_rdy = 1'b1;
    drain("t4_drain");
    // orphan B, then reset in the middle of a burst
    force_b = 1'b1;
    step();
    step();
    force_b = 1'b0;
    chk("t5_orphan", {err_orphan_b, outstanding, b_sel_valid}, {1'b1, 3'd0, 1'b0});
    step();
    chk("t5_sticky", err_orphan_b, 1'b1);
    w_rdy = 1'b0;
    exp_aw.push_back(1);
    pend[1] = 1;
    k = 0;
    while (!S_WVALID && k < 30) begin
      step();
      k++;
    end
    chk("t5_in_w", {S_WVALID, outstanding}, {1'b1, 3'd1});
    ARESETn = 1'b0;
    step();
    chk_reset("t5_reset_state");
    ARESETn = 1'b1;
    w_rdy = 1'b1;
    len[0] = 1;
    len[3] = 1;
    exp_aw = '{0, 3};
    pend[0] = 1;
    pend[3] = 1;
    drain("t5_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
